pll_phase_ctrl: RTL and testbench

Controller for the system EHXPLLL: filters the PLL `locked` signal, sequences the downstream clock-domain reset, and drives the PLL dynamic phase-adjust pins (PHASESEL/PHASEDIR/PHASESTEP) from a simple request handshake. It runs on the PLL reference clock (21.4773 MHz), which is free-running and independent of lock. It sits beside the PLL instance in the top level. SDRAM/video bring-up logic uses it to trim output clock phase at run time.

---
 rtl/pll_ctrl_pkg.sv | 29 ++
 rtl/pll_phase_ctrl_if.sv | 21 ++
 rtl/pll_lock_filter.sv | 62 ++++++
 rtl/pll_phase_ctrl.sv | 140 ++++++++++++++
 tb/tb_pll_phase_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types and defaults for the EHXPLLL lock/reset/phase-step controller.
// Holds the phase FSM encoding, PHASESEL codes and default timing constants.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_PULSE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } phase_state_e;

  localparam logic [1:0] SEL_CLKOS  = 2'd0;
  localparam logic [1:0] SEL_CLKOS2 = 2'd1;
  localparam logic [1:0] SEL_CLKOS3 = 2'd2;
  localparam logic [1:0] SEL_CLKOP  = 2'd3;

  localparam int LOCK_FILT_DEF = 1024;
  localparam int RST_HOLD_DEF  = 16;
  localparam int SETUP_CYC_DEF = 2;
  localparam int PULSE_CYC_DEF = 2;
  localparam int HOLD_CYC_DEF  = 4;

  // dir=0 delays (+1), dir=1 advances (-1); the 8-bit position wraps.
  function automatic logic [7:0] step_pos(input logic [7:0] pos, input logic dir);
    return dir ? (pos - 8'd1) : (pos + 8'd1);
  endfunction

endpackage

// File: rtl/pll_phase_ctrl_if.sv
// Phase-step request channel. A request transfers in a cycle where req_valid
// and req_ready are both high; done/err report completion one cycle wide.
interface pll_phase_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_sel;
  logic       req_dir;
  logic [7:0] req_steps;
  logic       done;
  logic       err;

  modport master (
    output req_valid, req_sel, req_dir, req_steps,
    input  req_ready, done, err
  );

  modport slave (
    input  req_valid, req_sel, req_dir, req_steps,
    output req_ready, done, err
  );
endinterface

// File: rtl/pll_lock_filter.sv
// Synchronises the raw PLL lock, filters it into pll_ready and sequences the
// downstream reset, which is held RST_HOLD cycles past pll_ready rising.
module pll_lock_filter
  import pll_ctrl_pkg::*;
#(
  parameter int LOCK_FILT = LOCK_FILT_DEF,
  parameter int RST_HOLD  = RST_HOLD_DEF
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic locked_i,
  output logic pll_ready_o,
  output logic rst_out_o
);

  localparam int LW = $clog2(LOCK_FILT + 1);
  localparam int HW = $clog2(RST_HOLD + 1);

  logic          sync1_q, sync2_q;
  logic [LW-1:0] lock_cnt_q, lock_cnt_d;
  logic          ready_q, ready_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          rst_q, rst_d;

  always_comb begin
    lock_cnt_d = '0;
    if (sync2_q) begin
      lock_cnt_d = (lock_cnt_q == LW'(LOCK_FILT)) ? lock_cnt_q : lock_cnt_q + 1'b1;
    end
    ready_d = (lock_cnt_d == LW'(LOCK_FILT));

    hold_cnt_d = '0;
    rst_d      = 1'b1;
    if (ready_q) begin
      hold_cnt_d = (hold_cnt_q == HW'(RST_HOLD)) ? hold_cnt_q : hold_cnt_q + 1'b1;
      rst_d      = (hold_cnt_d != HW'(RST_HOLD));
    end
  end

  // Sync flops clear on reset so bring-up timing counts from reset release.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      lock_cnt_q <= '0;
      ready_q    <= 1'b0;
      hold_cnt_q <= '0;
      rst_q      <= 1'b1;
    end else begin
      sync1_q    <= locked_i;
      sync2_q    <= sync1_q;
      lock_cnt_q <= lock_cnt_d;
      ready_q    <= ready_d;
      hold_cnt_q <= hold_cnt_d;
      rst_q      <= rst_d;
    end
  end

  assign pll_ready_o = ready_q;
  assign rst_out_o   = rst_q;

endmodule

// File: rtl/pll_phase_ctrl.sv
// EHXPLLL controller top: lock filter plus the PHASESEL/PHASEDIR/PHASESTEP
// sequencer that trims one output clock per request and tracks positions.
module pll_phase_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int LOCK_FILT = LOCK_FILT_DEF,
  parameter int RST_HOLD  = RST_HOLD_DEF,
  parameter int SETUP_CYC = SETUP_CYC_DEF,
  parameter int PULSE_CYC = PULSE_CYC_DEF,
  parameter int HOLD_CYC  = HOLD_CYC_DEF
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               locked_i,
  pll_phase_ctrl_if.slave    req,
  output logic [31:0]        phase_pos_o,
  output logic               pll_ready_o,
  output logic               rst_out_o,
  output logic [1:0]         phasesel_o,
  output logic               phasedir_o,
  output logic               phasestep_o,
  output logic               phaseloadreg_o,
  output phase_state_e       state_o
);

  localparam int CW = 8;

  logic          pll_ready;
  logic          req_ready;
  phase_state_e  state_q;
  logic [CW-1:0] cyc_q, last_cyc;
  logic [7:0]    rem_q;
  logic [1:0]    sel_q;
  logic          dir_q;
  logic          step_q;
  logic          done_q;
  logic          err_q;
  logic [31:0]   pos_q;

  pll_lock_filter #(
    .LOCK_FILT (LOCK_FILT),
    .RST_HOLD  (RST_HOLD)
  ) u_lock (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .locked_i    (locked_i),
    .pll_ready_o (pll_ready),
    .rst_out_o   (rst_out_o)
  );

  always_comb begin
    last_cyc = '0;
    unique case (state_q)
      ST_SETUP: last_cyc = CW'(SETUP_CYC - 1);
      ST_PULSE: last_cyc = CW'(PULSE_CYC - 1);
      ST_HOLD:  last_cyc = CW'(HOLD_CYC - 1);
      default:  last_cyc = '0;
    endcase
  end

  assign req_ready = (state_q == ST_IDLE) && pll_ready;

  // Lock loss outranks a timed exit, so a cut-short pulse never moves phase_pos.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      rem_q   <= '0;
      sel_q   <= SEL_CLKOS;
      dir_q   <= 1'b0;
      step_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      pos_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req.req_valid && req_ready) begin
            rem_q <= req.req_steps;
            cyc_q <= '0;
            if (req.req_steps == 8'd0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_SETUP;
              sel_q   <= req.req_sel;
              dir_q   <= req.req_dir;
            end
          end
        end
        ST_SETUP, ST_PULSE, ST_HOLD: begin
          if (!pll_ready) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            step_q  <= 1'b1;
            cyc_q   <= '0;
          end else if (cyc_q != last_cyc) begin
            cyc_q <= cyc_q + 1'b1;
          end else begin
            cyc_q <= '0;
            if (state_q == ST_SETUP) begin
              state_q <= ST_PULSE;
              step_q  <= 1'b0;
            end else if (state_q == ST_PULSE) begin
              state_q <= ST_HOLD;
              step_q  <= 1'b1;
              pos_q[{sel_q, 3'b000} +: 8] <= step_pos(pos_q[{sel_q, 3'b000} +: 8], dir_q);
              rem_q   <= rem_q - 1'b1;
            end else if (rem_q != 8'd0) begin
              state_q <= ST_PULSE;
              step_q  <= 1'b0;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req.req_ready   = req_ready;
  assign req.done        = done_q;
  assign req.err         = err_q;
  assign phase_pos_o     = pos_q;
  assign pll_ready_o     = pll_ready;
  assign phasesel_o      = sel_q;
  assign phasedir_o      = dir_q;
  assign phasestep_o     = step_q;
  assign phaseloadreg_o  = 1'b1;
  assign state_o         = state_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Bench for pll_phase_ctrl: lock bring-up/glitch, directed and random phase
// requests, lock loss mid-sequence and reset mid-pulse against a timing model.
module tb_pll_phase_ctrl;
  import pll_ctrl_pkg::*;

  localparam int LF = 1024;
  localparam int RH = 16;
  localparam int S  = 2;
  localparam int P  = 2;
  localparam int H  = 4;
  localparam int PH = P + H;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         locked = 1'b0;
  logic [31:0]  phase_pos;
  logic         pll_ready, rst_out, phasedir, phasestep, phaseloadreg;
  logic [1:0]   phasesel;
  phase_state_e state;

  pll_phase_ctrl_if req_if();

  pll_phase_ctrl dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .locked_i       (locked),
    .req            (req_if.slave),
    .phase_pos_o    (phase_pos),
    .pll_ready_o    (pll_ready),
    .rst_out_o      (rst_out),
    .phasesel_o     (phasesel),
    .phasedir_o     (phasedir),
    .phasestep_o    (phasestep),
    .phaseloadreg_o (phaseloadreg),
    .state_o        (state)
  );

  // clock/reset and cycle index (index is the cycle after the latest edge)
  always #5 clk = ~clk;
  int unsigned cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int          n_checks = 0;
  int          n_errs   = 0;
  logic [7:0]  pos_m [4];
  logic [31:0] exp_q [$];
  bit          pre_acc = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_word(input logic [1:0] sel, input logic [7:0] v);
    logic [7:0] p [4];
    for (int i = 0; i < 4; i++) p[i] = pos_m[i];
    p[sel] = v;
    return {p[3], p[2], p[1], p[0]};
  endfunction

  // pulses whose position update is visible by cycle x (cycle 1 = first after accept)
  function automatic int pulses_vis(input int x, input int n);
    int c;
    if (x < 1 + S + P) return 0;
    c = (x - 1 - S - P) / PH + 1;
    return (c > n) ? n : c;
  endfunction

  task automatic step_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pll_ready"}, pll_ready, 0);
    check({tag, "_rst_out"}, rst_out, 1);
    check({tag, "_req_ready"}, req_if.req_ready, 0);
    check({tag, "_done"}, req_if.done, 0);
    check({tag, "_err"}, req_if.err, 0);
    check({tag, "_phase_pos"}, phase_pos, 0);
    check({tag, "_phasesel"}, phasesel, 0);
    check({tag, "_phasedir"}, phasedir, 0);
    check({tag, "_phasestep"}, phasestep, 1);
    check({tag, "_phaseloadreg"}, phaseloadreg, 1);
    check({tag, "_state"}, 32'(state), 32'(ST_IDLE));
  endtask

  // Called just after an edge; exp_cyc is the first cycle pll_ready should be high.
  task automatic wait_ready(input int unsigned exp_cyc, input string tag);
    logic early = 1'b0;
    @(negedge clk);
    while (!pll_ready && cyc_n < exp_cyc + 64) begin
      if (req_if.req_ready) early = 1'b1;
      @(negedge clk);
    end
    check({tag, "_ready_cycle"}, cyc_n, exp_cyc);
    check({tag, "_req_ready_while_unlocked"}, early, 0);
    check({tag, "_rst_at_ready"}, rst_out, 1);
    while (rst_out && cyc_n < exp_cyc + RH + 64) @(negedge clk);
    check({tag, "_rst_release_cycle"}, cyc_n, exp_cyc + RH);
    step_cycle();
  endtask

  // drop_at > 0: locked goes low at the start of that cycle after accept.
  task automatic do_req(input logic [1:0] sel, input logic dir, input logic [7:0] steps,
                        input int drop_at, input bit hold);
    int n, len, le, k, kx, w;
    bit abort;
    logic [7:0] base, v;
    n     = int'(steps);
    len   = (n == 0) ? 1 : 1 + S + n * PH;
    abort = (drop_at > 0) && (drop_at + 4 < len);
    le    = abort ? drop_at + 4 : len;
    base  = pos_m[sel];
    if (!pre_acc) begin
      req_if.req_valid = 1'b1;
      req_if.req_sel   = sel;
      req_if.req_dir   = dir;
      req_if.req_steps = steps;
      w = 0;
      @(negedge clk);
      while (!req_if.req_ready && w < 3000) begin
        w++;
        @(negedge clk);
      end
      if (!req_if.req_ready) begin
        check("accept_timeout", 0, 1);
        req_if.req_valid = 1'b0;
        step_cycle();
        return;
      end
    end
    kx = pulses_vis(abort ? drop_at + 3 : len, n);
    v  = dir ? 8'(base - kx) : 8'(base + kx);
    exp_q.push_back(model_word(sel, v));
    for (int t = 1; t <= le + 1; t++) begin
      if (!(t == 1 && pre_acc)) step_cycle();
      if (t == 1 && !hold) req_if.req_valid = 1'b0;
      if (t == drop_at) locked = 1'b0;
      @(negedge clk);
      k = pulses_vis((abort && t > drop_at + 3) ? drop_at + 3 : t, n);
      check($sformatf("phasestep_t%0d", t), phasestep,
            !(t < le && t >= 1 + S && ((t - 1 - S) % PH) < P));
      check($sformatf("done_t%0d", t), req_if.done, (t == le));
      check($sformatf("phase_pos_t%0d", t), phase_pos,
            model_word(sel, dir ? 8'(base - k) : 8'(base + k)));
      if (n != 0) begin
        check($sformatf("phasesel_t%0d", t), phasesel, sel);
        check($sformatf("phasedir_t%0d", t), phasedir, dir);
      end
      if (t == le) begin
        check("err_at_done", req_if.err, abort);
        check("scoreboard_pos", phase_pos, exp_q.pop_front());
        if (abort) check("rst_out_after_loss", rst_out, 1);
      end
      check($sformatf("req_ready_t%0d", t), req_if.req_ready, (t == le + 1) && !abort);
    end
    pos_m[sel] = v;
    pre_acc = hold;
    step_cycle();
  endtask

  initial begin
    int unsigned c0, g1, rc;
    int w;
    logic seen_done;
    logic [1:0] rs;
    logic       rd;
    logic [7:0] rn;

    for (int i = 0; i < 4; i++) pos_m[i] = 8'd0;
    req_if.req_valid = 1'b0;
    req_if.req_sel   = 2'd0;
    req_if.req_dir   = 1'b0;
    req_if.req_steps = 8'd0;

    repeat (3) step_cycle();
    @(negedge clk);
    check_reset_vals("por");

    // bring-up with a one-cycle glitch when the filter count is at 500
    step_cycle();
    reset  = 1'b0;
    locked = 1'b1;
    c0 = cyc_n;
    while (cyc_n < c0 + 502) step_cycle();
    locked = 1'b0;
    step_cycle();
    locked = 1'b1;
    g1 = cyc_n;
    wait_ready(g1 + 2 + LF, "bringup");

    do_req(SEL_CLKOS2, 1'b0, 8'd1, 0, 1'b0);
    do_req(SEL_CLKOP, 1'b1, 8'd3, 0, 1'b0);
    do_req(SEL_CLKOS3, 1'b0, 8'd0, 0, 1'b0);
    do_req(SEL_CLKOS, 1'b0, 8'd2, 0, 1'b1);
    do_req(SEL_CLKOS, 1'b0, 8'd2, 0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      rs = 2'($urandom_range(0, 3));
      rd = 1'($urandom_range(0, 1));
      rn = (i % 4 == 0) ? 8'd0 : 8'($urandom_range(1, 12));
      if (i == 7) rn = 8'($urandom_range(200, 255));
      do_req(rs, rd, rn, 0, 1'b0);
    end

    // lock loss lands pll_ready low inside the third pulse
    do_req(SEL_CLKOS, 1'b0, 8'd5, 13, 1'b0);
    locked = 1'b1;
    wait_ready(cyc_n + 2 + LF, "relock");
    do_req(SEL_CLKOS3, 1'b1, 8'd2, 0, 1'b0);

    // reset in the middle of a pulse
    req_if.req_valid = 1'b1;
    req_if.req_sel   = SEL_CLKOS3;
    req_if.req_dir   = 1'b1;
    req_if.req_steps = 8'd4;
    w = 0;
    @(negedge clk);
    while (!req_if.req_ready && w < 100) begin
      w++;
      @(negedge clk);
    end
    check("mid_reset_accept", req_if.req_ready, 1);
    step_cycle();
    req_if.req_valid = 1'b0;
    w = 0;
    @(negedge clk);
    while (phasestep && w < 20) begin
      w++;
      @(negedge clk);
    end
    check("mid_reset_pulse_seen", phasestep, 0);
    reset = 1'b1;
    step_cycle();
    reset = 1'b0;
    rc = cyc_n;
    @(negedge clk);
    check_reset_vals("mid_reset");
    seen_done = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (req_if.done) seen_done = 1'b1;
    end
    check("no_done_after_reset", seen_done, 0);
    for (int i = 0; i < 4; i++) pos_m[i] = 8'd0;
    exp_q.delete();
    step_cycle();
    wait_ready(rc + 2 + LF, "post_reset");
    do_req(2'($urandom_range(0, 3)), 1'b1, 8'd4, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

  initial begin
    #1000000;
    n_errs++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
